// File: rtl/alu_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_arbiter (with package rv32)                                 |
// | Purpose  : round-robin sharing of one combinational rv32 ALU between N      |
// |            valid/ready requesters, result held in a one-entry response reg. |
// | Option   : ALU_ARB_LOCK_EN adds req_lock[N] for owner-locked grant.         |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+

package rv32;
   typedef logic [31:0] word_t;
   typedef enum logic [3:0] {
      ADD  = 4'd0,
      SUB  = 4'd1,
      SLL  = 4'd2,
      SLT  = 4'd3,
      SLTU = 4'd4,
      XOR  = 4'd5,
      SRL  = 4'd6,
      SRA  = 4'd7,
      OR   = 4'd8,
      AND  = 4'd9,
      OP2  = 4'd10
   } fn_t;
endpackage

module alu_arbiter #(
   parameter int N    = 2,
   parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N-1:0]              req_valid,
   output logic [N-1:0]              req_ready,
   input  rv32::fn_t [N-1:0]         req_fn,
   input  logic [N-1:0][31:0]        req_op1,
   input  logic [N-1:0][31:0]        req_op2,
`ifdef ALU_ARB_LOCK_EN
   input  logic [N-1:0]              req_lock,
`endif
   output rv32::fn_t                 alu_fn,
   output rv32::word_t               alu_op1,
   output rv32::word_t               alu_op2,
   input  rv32::word_t               alu_out,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output rv32::word_t               rsp_data,
   output logic [ID_W-1:0]           rsp_id
);

   logic              r_rsp_valid;
   rv32::word_t       r_rsp_data;
   logic [ID_W-1:0]   r_rsp_id;
   logic [ID_W-1:0]   r_ptr;

   logic              w_can_accept;
   logic [N-1:0]      w_elig;
   logic              w_gnt_found;
   logic [ID_W-1:0]   w_gnt_idx;
   logic [ID_W-1:0]   w_cand;

`ifdef ALU_ARB_LOCK_EN
   logic              r_lock_active;
   logic [ID_W-1:0]   r_lock_owner;
`endif

   assign w_can_accept = ~r_rsp_valid | rsp_ready;

   // While a lock is held only its owner stays eligible.
   always_comb begin
      w_elig = req_valid & {N{w_can_accept}};
`ifdef ALU_ARB_LOCK_EN
      if (r_lock_active) begin
         w_elig = w_elig & (N'(1) << r_lock_owner);
      end
`endif
   end

   // Search starts one past the last grant and wraps, so the last winner is tried last.
   always_comb begin
      w_gnt_found = 1'b0;
      w_gnt_idx   = '0;
      w_cand      = '0;
      for (int k = 1; k <= N; k++) begin
         w_cand = ID_W'((int'(r_ptr) + k) % N);
         if (!w_gnt_found && w_elig[w_cand]) begin
            w_gnt_found = 1'b1;
            w_gnt_idx   = w_cand;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      alu_fn    = rv32::OP2;
      alu_op1   = '0;
      alu_op2   = '0;
      if (w_gnt_found) begin
         req_ready[w_gnt_idx] = 1'b1;
         alu_fn               = req_fn[w_gnt_idx];
         alu_op1              = req_op1[w_gnt_idx];
         alu_op2              = req_op2[w_gnt_idx];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_id    <= '0;
         r_ptr       <= ID_W'(N - 1);
      end else if (w_gnt_found) begin
         r_rsp_valid <= 1'b1;
         r_rsp_data  <= alu_out;
         r_rsp_id    <= w_gnt_idx;
         r_ptr       <= w_gnt_idx;
      end else if (rsp_ready) begin
         r_rsp_valid <= 1'b0;
      end
   end

`ifdef ALU_ARB_LOCK_EN
   // An owner transfer with lock deasserted is what releases the lock.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_lock_active <= 1'b0;
         r_lock_owner  <= '0;
      end else if (w_gnt_found) begin
         r_lock_active <= req_lock[w_gnt_idx];
         r_lock_owner  <= w_gnt_idx;
      end
   end
`endif

   assign rsp_valid = r_rsp_valid;
   assign rsp_data  = r_rsp_data;
   assign rsp_id    = r_rsp_id;

   // Requester protocol: a pending request holds its payload until accepted.
   for (genvar gi = 0; gi < N; gi++) begin : g_req_rules
      a_hold: assert property (@(posedge clk) disable iff (reset)
         (req_valid[gi] && !req_ready[gi]) |=>
         (req_valid[gi] && $stable({req_fn[gi], req_op1[gi], req_op2[gi]})));
   end

   a_idle_in_reset: assert property (@(posedge clk) reset |-> (req_valid == '0));

endmodule

`default_nettype wire
